// File: rtl/pipe_stage_buf.sv
// Generic valid/ready pipeline-stage register with optional 2-entry skid buffer,
// bubble/flush stage controls and a saturating backpressure (hold) cycle counter.
module pipe_stage_buf #(
  parameter int                DATA_W   = 160,
  parameter int                CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}},
  parameter int                SKID     = 1,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              bubble,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  hold_cnt
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              ready_q;

  logic              main_valid_next;
  logic [DATA_W-1:0] main_data_next;
  logic [CTRL_W-1:0] main_ctrl_next;
  logic              skid_valid_next;
  logic [DATA_W-1:0] skid_data_next;
  logic [CTRL_W-1:0] skid_ctrl_next;
  logic              accept;
  logic              drain;

  // In skid mode out_ready only reaches in_ready through ready_q.
  assign in_ready  = ~rst & ~flush & ~bubble &
                     ((SKID != 0) ? ready_q : (~main_valid | out_ready));
  assign accept    = in_valid & in_ready;
  assign drain     = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  // Next entry contents; empty entries always hold 0/NOP so outputs need no gating.
  always_comb begin
    main_valid_next = main_valid;
    main_data_next  = main_data;
    main_ctrl_next  = main_ctrl;
    skid_valid_next = skid_valid;
    skid_data_next  = skid_data;
    skid_ctrl_next  = skid_ctrl;
    if (flush) begin
      main_valid_next = 1'b0;
      main_data_next  = {DATA_W{1'b0}};
      main_ctrl_next  = CTRL_NOP;
      skid_valid_next = 1'b0;
      skid_data_next  = {DATA_W{1'b0}};
      skid_ctrl_next  = CTRL_NOP;
    end else if (skid_valid) begin
      if (drain) begin
        main_valid_next = 1'b1;
        main_data_next  = skid_data;
        main_ctrl_next  = skid_ctrl;
        skid_valid_next = 1'b0;
        skid_data_next  = {DATA_W{1'b0}};
        skid_ctrl_next  = CTRL_NOP;
      end else begin
        main_valid_next = main_valid;
        skid_valid_next = skid_valid;
      end
    end else if (drain || !main_valid) begin
      if (accept) begin
        main_valid_next = 1'b1;
        main_data_next  = in_data;
        main_ctrl_next  = in_ctrl;
      end else begin
        main_valid_next = 1'b0;
        main_data_next  = {DATA_W{1'b0}};
        main_ctrl_next  = CTRL_NOP;
      end
    end else if (accept) begin
      // Main is stalled: only reachable in skid mode.
      skid_valid_next = 1'b1;
      skid_data_next  = in_data;
      skid_ctrl_next  = in_ctrl;
    end else begin
      main_valid_next = main_valid;
    end
  end

  // Entry registers, registered ready and saturating hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= {DATA_W{1'b0}};
      main_ctrl  <= CTRL_NOP;
      skid_valid <= 1'b0;
      skid_data  <= {DATA_W{1'b0}};
      skid_ctrl  <= CTRL_NOP;
      ready_q    <= 1'b1;
      hold_cnt   <= {CNT_W{1'b0}};
    end else begin
      main_valid <= main_valid_next;
      main_data  <= main_data_next;
      main_ctrl  <= main_ctrl_next;
      skid_valid <= skid_valid_next;
      skid_data  <= skid_data_next;
      skid_ctrl  <= skid_ctrl_next;
      ready_q    <= ~skid_valid_next;
      if (main_valid && !out_ready && (hold_cnt != {CNT_W{1'b1}})) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end else begin
        hold_cnt <= hold_cnt;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed scenarios plus randomized traffic checked
// against a queue-based reference model (skid, non-skid and 4-bit-counter instances).
module tb_pipe_stage_buf;
  localparam int DW = 160;
  localparam int CW = 16;
  typedef logic [CW+DW-1:0] ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, bubble, flush, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic rdy1, ov1, rdy0, ov0, rdy4, ov4;
  logic [DW-1:0] od1, od0, od4;
  logic [CW-1:0] oc1, oc0, oc4;
  logic [1:0]    occ1, occ0, occ4;
  logic [15:0]   hc1, hc0;
  logic [3:0]    hc4;

  pipe_stage_buf #(.SKID(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_ctrl(in_ctrl), .bubble(bubble), .flush(flush), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_ctrl(oc1), .occupancy(occ1), .hold_cnt(hc1));
  pipe_stage_buf #(.SKID(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_ctrl(in_ctrl), .bubble(bubble), .flush(flush), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_ctrl(oc0), .occupancy(occ0), .hold_cnt(hc0));
  pipe_stage_buf #(.SKID(1), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_data(in_data),
    .in_ctrl(in_ctrl), .bubble(bubble), .flush(flush), .out_valid(ov4), .out_ready(out_ready),
    .out_data(od4), .out_ctrl(oc4), .occupancy(occ4), .hold_cnt(hc4));

  int checks = 0;
  int passed = 0;

  // Reference model: q1 serves both skid instances (capacity 2), q0 the plain register.
  ent_t q1[$];
  ent_t q0[$];
  int   hold1 = 0, hold0 = 0, hold4 = 0;

  function automatic bit rdy1_m();
    return !rst && !flush && !bubble && (q1.size() < 2);
  endfunction

  function automatic bit rdy0_m();
    return !rst && !flush && !bubble && (q0.size() == 0 || out_ready);
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: the model applies the pre-edge inputs, then return at the falling edge.
  task automatic step();
    bit a1, a0, d1, d0;
    @(posedge clk);
    a1 = in_valid && rdy1_m();
    a0 = in_valid && rdy0_m();
    d1 = (q1.size() != 0) && out_ready;
    d0 = (q0.size() != 0) && out_ready;
    if (rst) begin
      q1.delete(); q0.delete();
      hold1 = 0; hold0 = 0; hold4 = 0;
    end else begin
      if (q1.size() != 0 && !out_ready) begin
        if (hold1 < 65535) hold1++;
        if (hold4 < 15) hold4++;
      end
      if (q0.size() != 0 && !out_ready && hold0 < 65535) hold0++;
      if (flush) begin
        q1.delete(); q0.delete();
      end else begin
        if (d1) void'(q1.pop_front());
        if (a1) q1.push_back({in_ctrl, in_data});
        if (d0) void'(q0.pop_front());
        if (a0) q0.push_back({in_ctrl, in_data});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; bubble = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_ctrl = 16'h0; in_data = {DW{1'b0}};
    step(); step();
    #1;
    checks++; if ({rdy1, rdy0, rdy4} !== 3'b000) $display("FAIL reset_in_ready got=%b exp=000", {rdy1, rdy0, rdy4}); else passed++;
    checks++; if ({ov1, occ1, hc1, oc1} !== {1'b0, 2'd0, 16'd0, 16'h0}) $display("FAIL reset_state got=%h exp=0", {ov1, occ1, hc1, oc1}); else passed++;
    checks++; if (od1 !== {DW{1'b0}}) $display("FAIL reset_data got=%h exp=0", od1); else passed++;
    rst = 1'b0;
    #1;
    checks++; if ({rdy1, rdy0} !== 2'b11) $display("FAIL reset_release_ready got=%b exp=11", {rdy1, rdy0}); else passed++;
  endtask

  task automatic test_flow();
    logic [DW-1:0] da [3];
    for (int i = 0; i < 3; i++) begin
      step();
      da[i] = rnd_data();
      in_valid = 1'b1; in_ctrl = 16'(5 + i); in_data = da[i];
      #1;
      checks++; if (rdy1 !== 1'b1) $display("FAIL flow_ready got=%b exp=1", rdy1); else passed++;
      if (i > 0) begin
        checks++;
        if ({ov1, oc1, od1, occ1} !== {1'b1, 16'(4 + i), da[i-1], 2'd1})
          $display("FAIL flow_out got=%h exp=%h", oc1, 16'(4 + i));
        else passed++;
      end
    end
    step();
    in_valid = 1'b0;
    #1;
    checks++; if ({ov1, oc1, od1, occ1, hc1} !== {1'b1, 16'h7, da[2], 2'd1, 16'd0}) $display("FAIL flow_last got=%h/%0d exp=7/0", oc1, hc1); else passed++;
    step(); #1;
    checks++; if ({ov1, occ1} !== {1'b0, 2'd0}) $display("FAIL flow_empty got=%b/%0d exp=0/0", ov1, occ1); else passed++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] da, db;
    da = rnd_data(); db = rnd_data();
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'hA; in_data = da;
    #1;
    checks++; if (rdy1 !== 1'b1) $display("FAIL bp_ready_a got=%b exp=1", rdy1); else passed++;
    step();
    in_ctrl = 16'hB; in_data = db;
    #1;
    checks++; if ({rdy1, ov1, oc1, hc1} !== {1'b1, 1'b1, 16'hA, 16'd0}) $display("FAIL bp_ready_b got=%b/%h/%0d exp=1/a/0", rdy1, oc1, hc1); else passed++;
    for (int k = 1; k <= 3; k++) begin
      step();
      in_valid = 1'b0;
      #1;
      checks++;
      if ({occ1, rdy1, hc1, oc1} !== {2'd2, 1'b0, 16'(k), 16'hA})
        $display("FAIL bp_stall got=occ%0d rdy%b hold%0d exp=occ2 rdy0 hold%0d", occ1, rdy1, hc1, k);
      else passed++;
    end
    step();
    out_ready = 1'b1;
    #1;
    checks++; if ({occ1, rdy1, hc1, oc1, od1} !== {2'd2, 1'b0, 16'd4, 16'hA, da}) $display("FAIL bp_head_a got=occ%0d rdy%b hold%0d ctrl%h", occ1, rdy1, hc1, oc1); else passed++;
    step(); #1;
    checks++; if ({oc1, od1, occ1, hc1, rdy1} !== {16'hB, db, 2'd1, 16'd4, 1'b1}) $display("FAIL bp_head_b got=ctrl%h occ%0d hold%0d rdy%b", oc1, occ1, hc1, rdy1); else passed++;
    step(); #1;
    checks++; if ({ov1, occ1, hc1} !== {1'b0, 2'd0, 16'd4}) $display("FAIL bp_drained got=%b/%0d/%0d exp=0/0/4", ov1, occ1, hc1); else passed++;
  endtask

  task automatic test_bubble();
    logic [DW-1:0] da, dc;
    da = rnd_data(); dc = rnd_data();
    step();
    in_valid = 1'b1; in_ctrl = 16'h11; in_data = da;
    #1;
    checks++; if (rdy1 !== 1'b1) $display("FAIL bub_ready_a got=%b exp=1", rdy1); else passed++;
    step();
    bubble = 1'b1; in_ctrl = 16'h22; in_data = dc;
    #1;
    checks++; if ({rdy1, ov1, oc1, od1} !== {1'b0, 1'b1, 16'h11, da}) $display("FAIL bub_block got=rdy%b ctrl%h exp=rdy0 ctrl11", rdy1, oc1); else passed++;
    step();
    bubble = 1'b0;
    #1;
    checks++; if ({ov1, oc1, od1, occ1} !== {1'b0, 16'h0, {DW{1'b0}}, 2'd0}) $display("FAIL bub_nop got=v%b ctrl%h occ%0d exp=v0 ctrl0 occ0", ov1, oc1, occ1); else passed++;
    checks++; if (rdy1 !== 1'b1) $display("FAIL bub_release got=%b exp=1", rdy1); else passed++;
    step();
    in_valid = 1'b0;
    #1;
    checks++; if ({ov1, oc1, od1} !== {1'b1, 16'h22, dc}) $display("FAIL bub_c got=v%b ctrl%h exp=v1 ctrl22", ov1, oc1); else passed++;
    step(); #1;
    checks++; if (ov1 !== 1'b0) $display("FAIL bub_end got=%b exp=0", ov1); else passed++;
  endtask

  task automatic test_flush();
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h31; in_data = rnd_data();
    step();
    in_ctrl = 16'h32; in_data = rnd_data();
    step();
    flush = 1'b1; out_ready = 1'b1; in_ctrl = 16'h33; in_data = rnd_data();
    #1;
    checks++; if ({occ1, rdy1, rdy0, hc1} !== {2'd2, 1'b0, 1'b0, 16'd5}) $display("FAIL fl_pre got=occ%0d rdy%b%b hold%0d exp=occ2 rdy00 hold5", occ1, rdy1, rdy0, hc1); else passed++;
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if ({ov1, occ1, oc1, od1, hc1} !== {1'b0, 2'd0, 16'h0, {DW{1'b0}}, 16'd5}) $display("FAIL fl_post got=v%b occ%0d ctrl%h hold%0d exp=v0 occ0 ctrl0 hold5", ov1, occ1, oc1, hc1); else passed++;
    checks++; if ({ov0, occ0} !== {1'b0, 2'd0}) $display("FAIL fl_post_s0 got=%b/%0d exp=0/0", ov0, occ0); else passed++;
    step(); #1;
    checks++; if (ov1 !== 1'b0) $display("FAIL fl_dropped got=%b exp=0", ov1); else passed++;
  endtask

  task automatic test_skid0();
    logic [DW-1:0] dd [4];
    step();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; bubble = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
    dd[0] = rnd_data();
    in_valid = 1'b1; in_ctrl = 16'h41; in_data = dd[0];
    #1;
    checks++; if (rdy0 !== 1'b1) $display("FAIL s0_ready_empty got=%b exp=1", rdy0); else passed++;
    for (int i = 1; i < 4; i++) begin
      step();
      dd[i] = rnd_data();
      in_ctrl = 16'(16'h41 + i); in_data = dd[i];
      #1;
      checks++;
      if ({ov0, oc0, od0} !== {1'b1, 16'(16'h40 + i), dd[i-1]}) $display("FAIL s0_out got=%h exp=%h", oc0, 16'(16'h40 + i));
      else passed++;
      if (i == 1) begin
        checks++; if (rdy0 !== 1'b0) $display("FAIL s0_freeze got=%b exp=0", rdy0); else passed++;
        out_ready = 1'b1;
        #1;
      end
      checks++; if (rdy0 !== 1'b1) $display("FAIL s0_ready got=%b exp=1", rdy0); else passed++;
    end
    step();
    in_valid = 1'b0;
    #1;
    checks++; if ({oc0, od0, occ0} !== {16'h44, dd[3], 2'd1}) $display("FAIL s0_last got=%h/%0d exp=44/1", oc0, occ0); else passed++;
  endtask

  task automatic test_saturation();
    step();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0; in_valid = 1'b1; in_ctrl = 16'h51; in_data = rnd_data();
    step();
    in_ctrl = 16'h52; in_data = rnd_data();
    step();
    in_valid = 1'b0;
    repeat (19) step();
    #1;
    checks++; if ({hc4, occ4} !== {4'd15, 2'd2}) $display("FAIL sat_hold4 got=%0d/%0d exp=15/2", hc4, occ4); else passed++;
    checks++; if (hc1 !== 16'd20) $display("FAIL sat_hold16 got=%0d exp=20", hc1); else passed++;
    rst = 1'b1; in_valid = 1'b1;
    #1;
    checks++; if (rdy4 !== 1'b0) $display("FAIL sat_rst_ready got=%b exp=0", rdy4); else passed++;
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if ({ov4, occ4, hc4, oc4, od4} !== {1'b0, 2'd0, 4'd0, 16'h0, {DW{1'b0}}}) $display("FAIL sat_rst_state got=v%b occ%0d hold%0d ctrl%h", ov4, occ4, hc4, oc4); else passed++;
    checks++; if ({rdy4, hc1} !== {1'b1, 16'd0}) $display("FAIL sat_rst_misc got=%b/%0d exp=1/0", rdy4, hc1); else passed++;
  endtask

  task automatic test_random();
    ent_t e1, e0;
    for (int n = 0; n < 400; n++) begin
      step();
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 99) < 4);
      bubble    = ($urandom_range(0, 99) < 10);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_ctrl   = 16'($urandom);
      in_data   = rnd_data();
      #1;
      e1 = (q1.size() != 0) ? q1[0] : {(CW+DW){1'b0}};
      e0 = (q0.size() != 0) ? q0[0] : {(CW+DW){1'b0}};
      checks++; if ({rdy1, rdy4, rdy0} !== {rdy1_m(), rdy1_m(), rdy0_m()}) $display("FAIL rnd_ready n=%0d got=%b exp=%b%b%b", n, {rdy1, rdy4, rdy0}, rdy1_m(), rdy1_m(), rdy0_m()); else passed++;
      checks++; if ({ov1, oc1, od1, occ1} !== {q1.size() != 0, e1, 2'(q1.size())}) $display("FAIL rnd_s1 n=%0d got=ctrl%h occ%0d exp=ctrl%h occ%0d", n, oc1, occ1, e1[CW+DW-1:DW], q1.size()); else passed++;
      checks++; if ({ov4, oc4, od4, occ4} !== {q1.size() != 0, e1, 2'(q1.size())}) $display("FAIL rnd_s4 n=%0d got=ctrl%h occ%0d exp=ctrl%h occ%0d", n, oc4, occ4, e1[CW+DW-1:DW], q1.size()); else passed++;
      checks++; if ({ov0, oc0, od0, occ0} !== {q0.size() != 0, e0, 2'(q0.size())}) $display("FAIL rnd_s0 n=%0d got=ctrl%h occ%0d exp=ctrl%h occ%0d", n, oc0, occ0, e0[CW+DW-1:DW], q0.size()); else passed++;
      checks++; if ({hc1, hc4, hc0} !== {16'(hold1), 4'(hold4), 16'(hold0)}) $display("FAIL rnd_hold n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", n, hc1, hc4, hc0, hold1, hold4, hold0); else passed++;
    end
    rst = 1'b0; flush = 1'b0; bubble = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_flow();
    test_backpressure();
    test_bubble();
    test_flush();
    test_skid0();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
